pipe_hazard_unit: RTL
=====================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; sets perf-counter width only.
REQ-002 Parameter REGW, default 5, register-index width (4 for 16-register variant).
REQ-003 Parameter LOAD_LAT, default 1, range 1..3, load-use stall cycles.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 d_rs1, d_rs2  input  REGW each  decode-stage source indices.
REQ-008 d_use_rs1, d_use_rs2  input  1 each  decode instruction reads that source.
REQ-009 e_rs1, e_rs2  input  REGW each  execute-stage source indices.
REQ-010 e_rd, m_rd, w_rd  input  REGW each  destination index per stage.
REQ-011 e_wr, m_wr, w_wr  input  1 each  stage writes its rd.
REQ-012 e_load  input  1  execute-stage instruction is a load.
REQ-013 e_redirect  input  1  execute resolved a taken jump or branch.
REQ-014 w_fault  input  1  write-back instruction faulted.
REQ-015 stall_f, stall_d  output  1 each  hold PC and D registers.
REQ-016 flush_d, bubble_e  output  1 each  load NOP into D or E registers.
REQ-017 fwd_a, fwd_b  output  2 each  E operand select: 0 E register, 1 M valE, 2 W valR.
REQ-018 halted  output  1  core stopped after fault.
REQ-019 perf_stall, perf_flush  output  XLEN each  event counters (REQ-035).

Function
REQ-020 FSM states RUN, STALL, HALT; reset enters RUN.
REQ-021 Index 0 SHALL never cause a hazard or forward.
REQ-022 Load-use: RUN, e_load & e_wr & e_rd!=0 & e_rd matches a used d_rs -> STALL, counter=LOAD_LAT-1.
REQ-023 Load-use cycle and each STALL cycle: stall_f=1, stall_d=1, bubble_e=1, flush_d=0.
REQ-024 STALL: counter 0 -> RUN next cycle; else decrement; total stall exactly LOAD_LAT cycles.
REQ-025 e_redirect in RUN or STALL: flush_d=1, bubble_e=1, stall_f=0, stall_d=0 that cycle; next state RUN, counter cleared.
REQ-026 w_fault in any state -> HALT next edge; fault beats redirect and load-use same cycle.
REQ-027 HALT: stall_f=1, stall_d=1, bubble_e=1, flush_d=0, halted=1; exit only by reset.
REQ-028 Forwarding: fwd_a=1 if m_wr & m_rd!=0 & m_rd==e_rs1; else 2 if W matches; else 0; fwd_b likewise for e_rs2.
REQ-029 M match SHALL beat W match.
REQ-030 fwd_a/fwd_b combinational, valid all states; other outputs from FSM and current inputs.

Reset
REQ-031 While reset high: state RUN, counter 0, halted 0, perf counters 0.
REQ-032 While reset high flush_d=1, bubble_e=1, stall_f=0, stall_d=0.
REQ-033 Reset mid-STALL or in HALT aborts immediately; first post-reset cycle behaves as RUN.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN selects perf counters.
REQ-035 Defined: perf_stall +1 per cycle stall_d=1 outside HALT; perf_flush +1 per e_redirect cycle outside HALT; both wrap at 2^XLEN.
REQ-036 Undefined: perf_stall, perf_flush constant 0, no counter flops.

Verification
REQ-037 LOAD_LAT=1, e_load, e_wr, e_rd=5, d_rs1=5, d_use_rs1 -> one cycle stall_f=stall_d=bubble_e=1, then RUN.
REQ-038 LOAD_LAT=3, same stimulus -> exactly 3 stall cycles; e_redirect in 2nd -> flush_d=1, RUN next cycle.
REQ-039 m_rd=w_rd=7, both write, e_rs1=7, e_rs2=0 -> fwd_a=1, fwd_b=0; m_wr=0 -> fwd_a=2.
REQ-040 e_rd=0 load, d_rs1=0 -> no stall; m_rd=0 -> fwd 0.
REQ-041 w_fault with e_redirect same cycle -> HALT, halted=1, stall_f=1, flush_d=0; held until reset; reset -> flush_d=1, bubble_e=1.
REQ-042 HAZARD_PERF_CNT_EN defined, 3-cycle stall plus 2 redirects -> perf_stall=3, perf_flush=2.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stall FSM, redirect flush, fault halt and E-stage forwarding.
// Optional event counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [REGW-1:0] d_rs1,
  input  logic [REGW-1:0] d_rs2,
  input  logic            d_use_rs1,
  input  logic            d_use_rs2,
  input  logic [REGW-1:0] e_rs1,
  input  logic [REGW-1:0] e_rs2,
  input  logic [REGW-1:0] e_rd,
  input  logic [REGW-1:0] m_rd,
  input  logic [REGW-1:0] w_rd,
  input  logic            e_wr,
  input  logic            m_wr,
  input  logic            w_wr,
  input  logic            e_load,
  input  logic            e_redirect,
  input  logic            w_fault,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic            bubble_e,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            halted,
  output logic [XLEN-1:0] perf_stall,
  output logic [XLEN-1:0] perf_flush
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  // Extra stall cycles still owed after the load-use cycle itself.
  localparam logic [1:0] STALL_INIT = 2'(LOAD_LAT - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_cnt;
  logic [1:0]      w_nextCnt;
  logic            w_loadUse;

  assign w_loadUse = e_load && e_wr && (e_rd != '0) &&
                     ((d_use_rs1 && (d_rs1 == e_rd)) || (d_use_rs2 && (d_rs2 == e_rd)));

  function automatic logic [1:0] fwdSel(input logic [REGW-1:0] rs);
    if (m_wr && (m_rd != '0) && (m_rd == rs))
      return 2'd1;
    else if (w_wr && (w_rd != '0) && (w_rd == rs))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  assign fwd_a  = fwdSel(e_rs1);
  assign fwd_b  = fwdSel(e_rs2);
  assign halted = (r_state == HALT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    bubble_e    = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (reset) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end
        STALL: begin
          if (e_redirect) begin
            flush_d     = 1'b1;
            bubble_e    = 1'b1;
            w_nextState = RUN;
            w_nextCnt   = 2'd0;
          end else begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
            // r_cnt counts the STALL cycles left including this one.
            if (r_cnt <= 2'd1) begin
              w_nextState = RUN;
              w_nextCnt   = 2'd0;
            end else begin
              w_nextCnt = r_cnt - 2'd1;
            end
          end
        end
        default: begin
          w_nextCnt = 2'd0;
          if (e_redirect) begin
            flush_d  = 1'b1;
            bubble_e = 1'b1;
          end else if (w_loadUse) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            bubble_e = 1'b1;
            if (STALL_INIT != 2'd0) begin
              w_nextState = STALL;
              w_nextCnt   = STALL_INIT;
            end
          end
        end
      endcase
      if (w_fault) begin
        w_nextState = HALT;
        w_nextCnt   = 2'd0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [XLEN-1:0] r_perfStall;
  logic [XLEN-1:0] r_perfFlush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perfStall <= '0;
      r_perfFlush <= '0;
    end else if (r_state != HALT) begin
      if (stall_d)
        r_perfStall <= r_perfStall + XLEN'(1);
      if (e_redirect)
        r_perfFlush <= r_perfFlush + XLEN'(1);
    end
  end

  assign perf_stall = r_perfStall;
  assign perf_flush = r_perfFlush;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule
